controlador_varredura_matriz: RTL and testbench



---
 rtl/matriz_pkg.sv | 24 ++
 rtl/contador_m.sv | 26 ++
 rtl/controlador_varredura_matriz.sv | 140 ++++++++++++++
 tb/tb_controlador_varredura_matriz.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared types and constants for the 8x8 LED matrix row-scan controller.
package matriz_pkg;

  localparam int LARG_LINHA  = 8;
  localparam int LARG_QUADRO = 64;

  typedef enum logic [1:0] {
    APAGADO   = 2'd0,
    EXIBE     = 2'd1,
    FIM_LINHA = 2'd2
  } estado_t;

  localparam logic ATIVA_ALTA  = 1'b1;
  localparam logic ATIVA_BAIXA = 1'b0;

  // Maps a logical "on" pattern to the pin polarity.
  function automatic logic [LARG_LINHA-1:0] nivel(
    input logic [LARG_LINHA-1:0] v,
    input logic                  alta
  );
    return alta ? v : ~v;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic modulo counter with clear/enable; wraps and flags at a
// run-time terminal value.
module contador_m #(
  parameter int MODULO = 16,
  parameter int W      = (MODULO > 2) ? $clog2(MODULO) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  input  logic [W-1:0] ultimo,
  output logic [W-1:0] valor,
  output logic         fim
);

  assign fim = (valor == ultimo);

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      valor <= '0;
    end else if (conta) begin
      valor <= fim ? '0 : valor + 1'b1;
    end
  end

endmodule

// File: rtl/controlador_varredura_matriz.sv
// Double-buffered row-scan driver for the 8x8 LED matrix.
// Optional BRILHO_EN adds a per-row brightness (on-time) control.
module controlador_varredura_matriz
  import matriz_pkg::*;
#(
  parameter int CICLOS_LINHA      = 50000,
  parameter int CICLOS_APAGADO    = 500,
  parameter int LINHA_ATIVA_ALTA  = 1,
  parameter int COLUNA_ATIVA_ALTA = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilita,
  input  logic                   carregar,
  input  logic [LARG_QUADRO-1:0] quadro,
`ifdef BRILHO_EN
  input  logic [2:0]             brilho,
`endif
  output logic                   ocupado,
  output logic                   quadro_trocado,
  output logic [LARG_LINHA-1:0]  linhas,
  output logic [LARG_LINHA-1:0]  colunas,
  output logic [2:0]             db_linha
);

  localparam int MAXC =
    (CICLOS_LINHA > CICLOS_APAGADO) ? CICLOS_LINHA : CICLOS_APAGADO;
  localparam int WC = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic LA = (LINHA_ATIVA_ALTA != 0);
  localparam logic CA = (COLUNA_ATIVA_ALTA != 0);

  localparam logic [7:0] L_INAT = LA ? 8'h00 : 8'hFF;
  localparam logic [7:0] C_INAT = CA ? 8'h00 : 8'hFF;

  estado_t          estado, prox;
  logic [2:0]       linha, linha_n;
  logic [WC-1:0]    cnt, ultimo;
  logic             fim, limpa;
  logic [63:0]      ativo, sombra;
  logic             troca, aceita, acende;
  logic [7:0]       linhas_d, colunas_d;

  assign ultimo = (estado == EXIBE) ? WC'(CICLOS_LINHA - 1)
                                    : WC'(CICLOS_APAGADO - 1);
  assign limpa  = !habilita || (estado == FIM_LINHA);

  contador_m #(
    .MODULO (MAXC),
    .W      (WC)
  ) u_slot (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa),
    .conta  (1'b1),
    .ultimo (ultimo),
    .valor  (cnt),
    .fim    (fim)
  );

  // Swap only at the frame boundary, or at once while the scan is off.
  assign troca = !reset && ocupado &&
                 (!habilita || (estado == FIM_LINHA && linha == 3'd7));
  assign aceita = carregar && (!ocupado || troca);
  assign quadro_trocado = troca;
  assign db_linha = linha;

`ifdef BRILHO_EN
  logic [2:0]  brilho_q;
  logic [31:0] limite;
  assign limite = ((32'(brilho_q) + 32'd1) * 32'(CICLOS_LINHA)) >> 3;
  assign acende = (32'(cnt) < limite);
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  assign acende = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= APAGADO;
      linha  <= '0;
    end else begin
      estado <= prox;
      linha  <= linha_n;
    end
  end

  always_comb begin
    prox    = estado;
    linha_n = linha;
    if (!habilita) begin
      prox    = APAGADO;
      linha_n = '0;
    end else begin
      unique case (estado)
        APAGADO:   if (fim) prox = EXIBE;
        EXIBE:     if (fim) prox = FIM_LINHA;
        FIM_LINHA: begin
          prox    = APAGADO;
          linha_n = linha + 3'd1;
        end
        default:   prox = APAGADO;
      endcase
    end
  end

  always_comb begin
    linhas_d  = L_INAT;
    colunas_d = C_INAT;
    if (habilita && estado == EXIBE) begin
      linhas_d = nivel(8'd1 << linha, LA);
      if (acende) colunas_d = nivel(ativo[{linha, 3'b000} +: 8], CA);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ativo   <= '0;
      sombra  <= '0;
      ocupado <= 1'b0;
      linhas  <= L_INAT;
      colunas <= C_INAT;
`ifdef BRILHO_EN
      brilho_q <= '0;
`endif
    end else begin
      if (troca)  ativo  <= sombra;
      if (aceita) sombra <= quadro;
      if (aceita)     ocupado <= 1'b1;
      else if (troca) ocupado <= 1'b0;
      linhas  <= linhas_d;
      colunas <= colunas_d;
`ifdef BRILHO_EN
      if (estado == APAGADO && prox == EXIBE) brilho_q <= brilho;
`endif
    end
  end

endmodule

// File: tb/tb_controlador_varredura_matriz.sv
// Self-checking bench for controlador_varredura_matriz using a
// phase-arithmetic reference model of the scan and frame buffers.
module tb_controlador_varredura_matriz;

  localparam int CL = 8;
  localparam int AP = 2;
  localparam int RP = AP + CL + 1;
  localparam int FP = 8 * RP;

  logic        clock = 0;
  logic        reset;
  logic        habilita;
  logic        carregar;
  logic [63:0] quadro;
  logic [2:0]  brilho;
  logic        ocupado, quadro_trocado;
  logic [7:0]  linhas, colunas;
  logic [2:0]  db_linha;

  int total = 0;
  int bad   = 0;

  int          m_s;
  logic [63:0] m_act, m_sh;
  bit          m_oc;
  int          m_b;

  controlador_varredura_matriz #(
    .CICLOS_LINHA      (CL),
    .CICLOS_APAGADO    (AP),
    .LINHA_ATIVA_ALTA  (1),
    .COLUNA_ATIVA_ALTA (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .carregar       (carregar),
    .quadro         (quadro),
`ifdef BRILHO_EN
    .brilho         (brilho),
`endif
    .ocupado        (ocupado),
    .quadro_trocado (quadro_trocado),
    .linhas         (linhas),
    .colunas        (colunas),
    .db_linha       (db_linha)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1;
    habilita = 0;
    carregar = 0;
    quadro   = '0;
    brilho   = 3'd7;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_linhas", 64'(linhas), 64'h00);
    chk("rst_colunas", 64'(colunas), 64'hFF);
    chk("rst_ocupado", 64'(ocupado), 64'h0);
    chk("rst_db_linha", 64'(db_linha), 64'h0);
    chk("rst_trocado", 64'(quadro_trocado), 64'h0);
    reset = 0;
    m_s = 0; m_act = '0; m_sh = '0; m_oc = 0; m_b = 0;
  endtask

  task automatic step();
    logic [63:0] act_old;
    logic [7:0]  el, ec, bits;
    int          pos, row;
    bit          swap, load, lit, cheio;
    @(negedge clock);
    swap = m_oc && (!habilita || m_s == FP - 1);
    chk("trocado", 64'(quadro_trocado), 64'(swap));
    chk("ocupado", 64'(ocupado), 64'(m_oc));
    act_old = m_act;
    pos = m_s % RP;
    row = m_s / RP;
    lit = habilita && pos >= AP && pos < AP + CL;
`ifdef BRILHO_EN
    cheio = (pos - AP) < ((m_b + 1) * CL) / 8;
`else
    cheio = 1;
`endif
    bits = act_old[row*8 +: 8];
    el = lit ? 8'(1 << row) : 8'h00;
    ec = (lit && cheio) ? ~bits : 8'hFF;
    if (habilita && pos == AP - 1) m_b = int'(brilho);
    load = carregar && (!m_oc || swap);
    if (swap) m_act = m_sh;
    if (load) m_sh = quadro;
    m_oc = load ? 1'b1 : (swap ? 1'b0 : m_oc);
    m_s = habilita ? (m_s + 1) % FP : 0;
    @(posedge clock);
    #1;
    chk("linhas", 64'(linhas), 64'(el));
    chk("colunas", 64'(colunas), 64'(ec));
    chk("db_linha", 64'(db_linha), 64'(m_s / RP));
  endtask

  task automatic run_to(input int alvo);
    int n = 0;
    while (m_s != alvo && n < 2 * FP) begin
      step();
      n++;
    end
    chk("run_to_reached", 64'(m_s), 64'(alvo));
  endtask

  task automatic rnd_cycles(input int n, input int prob);
    for (int i = 0; i < n; i++) begin
      carregar = ($urandom_range(prob - 1) == 0);
      quadro   = {$urandom, $urandom};
      brilho   = 3'($urandom_range(7));
      step();
    end
    carregar = 0;
  endtask

  initial begin
    do_reset();

    // Diagonal frame, then an ignored all-ones load while busy.
    habilita = 1;
    carregar = 1;
    quadro   = 64'h8040201008040201;
    step();
    quadro = '1;
    step();
    carregar = 0;
    chk("busy_after_load", 64'(ocupado), 64'h1);
    for (int i = 0; i < 3 * FP; i++) step();
    chk("idle_after_swap", 64'(ocupado), 64'h0);

    // Load A mid-frame, load B exactly in the row-7 FIM_LINHA cycle.
    run_to(20);
    carregar = 1;
    quadro   = 64'hF00F_AA55_0FF0_55AA;
    step();
    carregar = 0;
    run_to(FP - 1);
    carregar = 1;
    quadro   = 64'h0123_4567_89AB_CDEF;
    step();
    carregar = 0;
    chk("busy_after_swap_load", 64'(ocupado), 64'h1);
    for (int i = 0; i < 2 * FP; i++) step();

    rnd_cycles(300, 6);

    // Disable mid-row 4 with traffic while off, then re-enable.
    run_to(4 * RP + AP + 3);
    habilita = 0;
    rnd_cycles(20, 3);
    habilita = 1;
    for (int i = 0; i < FP + 10; i++) step();
    rnd_cycles(250, 5);

    // Reset mid-scan with a pending shadow frame.
    carregar = 1;
    quadro   = {$urandom, $urandom};
    step();
    carregar = 0;
    step();
    do_reset();
    habilita = 1;
    for (int i = 0; i < FP + 5; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
